pc_sequencer: RTL and testbench

//  Owns the architectural program counter of the single-cycle RV32I core and picks its next value each cycle.

---
 rtl/pc_ctrl_pkg.sv | 24 ++
 rtl/full_adder_32bit.sv | 20 ++
 rtl/pc_reg.sv | 22 ++
 rtl/pc_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg
//   Shared types and constants for the program-counter sequencer.
//   Contents:
//     pc_state_e        FSM state encoding (visible on state_o for debug)
//     INSTR_ALIGN_MASK  low PC bits that must be zero for a legal RV32I target
//     is_misaligned()   true when an address violates INSTR_ALIGN_MASK
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_BOOT = 2'b00,
      PC_RUN  = 2'b01,
      PC_TRAP = 2'b10,
      PC_HALT = 2'b11
   } pc_state_e;

   localparam logic [31:0] INSTR_ALIGN_MASK = 32'h3;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr & INSTR_ALIGN_MASK) != 32'h0;
   endfunction

endpackage : pc_ctrl_pkg

// File: rtl/full_adder_32bit.sv
// ---------------------------------------------------------------------------
// full_adder_32bit
//   32-bit adder with carry-in. The sum wraps modulo 2^32; the carry-out is
//   deliberately not exported because no caller needs it.
//   Ports:
//     a    in  32  first operand
//     b    in  32  second operand
//     cin  in  1   carry in
//     sum  out 32  a + b + cin, modulo 2^32
// ---------------------------------------------------------------------------
module full_adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum
);

   assign sum = a + b + {31'b0, cin};

endmodule : full_adder_32bit

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
//   Sequential-increment path of the PC: produces pc + 4 for the next-PC mux
//   and for the JAL/JALR link value. Wraps silently at the top of the
//   address space (32'hFFFF_FFFC + 4 = 32'h0).
//   Ports:
//     pc        in  32  current program counter
//     pc_plus4  out 32  pc + 4, modulo 2^32
// ---------------------------------------------------------------------------
module pc_reg (
   input  logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   full_adder_32bit u_add4 (
      .a   (pc),
      .b   (32'd4),
      .cin (1'b0),
      .sum (pc_plus4)
   );

endmodule : pc_reg

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Owns the architectural PC of the single-cycle RV32I core and selects its
//   next value each cycle. Next-PC candidates, highest priority first:
//   trap vector, branch/jump redirect, hold (stall / imem busy), PC + 4.
//   Adds a boot delay after reset, a debug halt/resume hook and trapping of
//   misaligned redirect targets.
//
//   Parameters:
//     RESET_VECTOR  first fetch address after reset
//     TRAP_VECTOR   PC loaded on any trap
//     BOOT_CYCLES   cycles spent in BOOT before the first fetch (0 = none)
//
//   Ports:
//     clk_i          in   1   core clock, rising edge
//     rst_ni         in   1   asynchronous active-low reset
//     imem_ready_i   in   1   imem accepts an address; 0 holds the PC
//     stall_i        in   1   hazard stall; 1 holds the PC
//     redirect_i     in   1   taken branch/jump
//     redirect_pc_i  in   32  branch/jump target
//     trap_i         in   1   exception / ecall request
//     halt_i         in   1   debug halt request
//     resume_i       in   1   debug resume request
//     pc_o           out  32  current PC (registered)
//     pc_plus4_o     out  32  pc_o + 4 (combinational)
//     fetch_valid_o  out  1   high only in RUN
//     epc_o          out  32  PC of the trapping instruction (registered)
//     misalign_o     out  1   one-cycle pulse on a misaligned redirect target
//     state_o        out  2   current FSM state
// ---------------------------------------------------------------------------
module pc_sequencer
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned BOOT_CYCLES  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        imem_ready_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        trap_i,
   input  logic        halt_i,
   input  logic        resume_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        fetch_valid_o,
   output logic [31:0] epc_o,
   output logic        misalign_o,
   output logic [1:0]  state_o
);

   localparam int unsigned BOOT_W = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);
   localparam logic [BOOT_W-1:0] BOOT_LAST =
      BOOT_W'((BOOT_CYCLES > 0) ? (BOOT_CYCLES - 1) : 0);
   // With no boot delay the sequencer comes out of reset already fetching.
   localparam pc_state_e RESET_STATE = (BOOT_CYCLES == 0) ? PC_RUN : PC_BOOT;

   pc_state_e         state_reg, state_next;
   logic [31:0]       pc_val_reg, pc_next;
   logic [31:0]       epc_reg, epc_next;
   logic              misalign_reg, misalign_next;
   logic [BOOT_W-1:0] boot_cnt_reg, boot_cnt_next;
   logic [31:0]       pc_plus4;

   pc_reg u_pc_reg (
      .pc       (pc_val_reg),
      .pc_plus4 (pc_plus4)
   );

   // ------------------------------------------------------------------
   // Next-state / next-PC selection
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_val_reg;
      epc_next      = epc_reg;
      misalign_next = 1'b0;
      boot_cnt_next = boot_cnt_reg;

      unique case (state_reg)
         PC_BOOT: begin
            // Requests are ignored until the first fetch.
            pc_next       = RESET_VECTOR;
            boot_cnt_next = boot_cnt_reg + BOOT_W'(1);
            if (boot_cnt_reg == BOOT_LAST) begin
               state_next = PC_RUN;
            end
         end

         PC_RUN: begin
            if (trap_i) begin
               epc_next   = pc_val_reg;
               pc_next    = TRAP_VECTOR;
               state_next = PC_TRAP;
            end else if (redirect_i && is_misaligned(redirect_pc_i)) begin
               misalign_next = 1'b1;
               epc_next      = pc_val_reg;
               pc_next       = TRAP_VECTOR;
               state_next    = PC_TRAP;
            end else if (halt_i) begin
               // An aligned redirect in the same cycle is dropped.
               state_next = PC_HALT;
            end else if (redirect_i) begin
               pc_next = redirect_pc_i;
            end else if (stall_i || !imem_ready_i) begin
               pc_next = pc_val_reg;
            end else begin
               pc_next = pc_plus4;
            end
         end

         PC_TRAP: begin
            // PC already sits at the trap vector; this cycle only flushes.
            state_next = PC_RUN;
         end

         PC_HALT: begin
            if (resume_i) begin
               state_next = PC_RUN;
            end
         end

         default: begin
            state_next = RESET_STATE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= RESET_STATE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_val_reg <= RESET_VECTOR;
      end else begin
         pc_val_reg <= pc_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         epc_reg <= 32'h0;
      end else begin
         epc_reg <= epc_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         misalign_reg <= 1'b0;
      end else begin
         misalign_reg <= misalign_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         boot_cnt_reg <= '0;
      end else begin
         boot_cnt_reg <= boot_cnt_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign pc_o          = pc_val_reg;
   assign pc_plus4_o    = pc_plus4;
   assign fetch_valid_o = (state_reg == PC_RUN);
   assign epc_o         = epc_reg;
   assign misalign_o    = misalign_reg;
   assign state_o       = state_reg;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed, table-driven bench for pc_sequencer (default parameters:
//   RESET_VECTOR=0, TRAP_VECTOR=0x100, BOOT_CYCLES=2). Each table row holds
//   the inputs applied before a rising edge and the outputs expected just
//   after it. Reset checks and the asynchronous reset during HALT are
//   written out by hand.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_TRAP = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;
   localparam int         NVEC    = 35;

   logic        clk;
   logic        rst_ni;
   logic        imem_ready;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        trap;
   logic        halt;
   logic        resume;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic [31:0] epc;
   logic        misalign;
   logic [1:0]  state;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic        trap;
      logic        redir;
      logic [31:0] rpc;
      logic        stall;
      logic        rdy;
      logic        halt;
      logic        resume;
      logic [31:0] exp_pc;
      logic [1:0]  exp_state;
      logic [31:0] exp_epc;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [NVEC];

   pc_sequencer dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .imem_ready_i  (imem_ready),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .trap_i        (trap),
      .halt_i        (halt),
      .resume_i      (resume),
      .pc_o          (pc),
      .pc_plus4_o    (pc_plus4),
      .fetch_valid_o (fetch_valid),
      .epc_o         (epc),
      .misalign_o    (misalign),
      .state_o       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic t, input logic r, input logic [31:0] rp,
                               input logic s, input logic rd, input logic h, input logic rs,
                               input logic [31:0] epc_v, input logic [1:0] st,
                               input logic [31:0] e, input logic m);
      vec_t v;
      v.trap = t; v.redir = r; v.rpc = rp; v.stall = s; v.rdy = rd;
      v.halt = h; v.resume = rs; v.exp_pc = epc_v; v.exp_state = st;
      v.exp_epc = e; v.exp_mis = m;
      return v;
   endfunction

   task automatic idle_inputs();
      trap = 0; redirect = 0; redirect_pc = 32'h0; stall = 0;
      imem_ready = 1; halt = 0; resume = 0;
   endtask

   initial begin
      //                 trap redir rpc           stall rdy halt res  pc            state    epc    mis
      // boot: requests ignored, two cycles with valid=0
      vecs[0]  = mk(1, 0, 32'h0,        0, 1, 0, 0,  32'h0,        ST_BOOT, 32'h0,  0);
      vecs[1]  = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h0,        ST_RUN,  32'h0,  0);
      vecs[2]  = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h4,        ST_RUN,  32'h0,  0);
      vecs[3]  = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h8,        ST_RUN,  32'h0,  0);
      vecs[4]  = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'hC,        ST_RUN,  32'h0,  0);
      // redirect, redirect beats stall, stall hold, imem-not-ready hold
      vecs[5]  = mk(0, 1, 32'h10,       0, 1, 0, 0,  32'h10,       ST_RUN,  32'h0,  0);
      vecs[6]  = mk(0, 1, 32'h40,       1, 1, 0, 0,  32'h40,       ST_RUN,  32'h0,  0);
      vecs[7]  = mk(0, 0, 32'h0,        1, 1, 0, 0,  32'h40,       ST_RUN,  32'h0,  0);
      vecs[8]  = mk(0, 0, 32'h0,        0, 0, 0, 0,  32'h40,       ST_RUN,  32'h0,  0);
      vecs[9]  = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h44,       ST_RUN,  32'h0,  0);
      // misaligned redirect -> trap with misalign pulse
      vecs[10] = mk(0, 1, 32'h20,       0, 1, 0, 0,  32'h20,       ST_RUN,  32'h0,  0);
      vecs[11] = mk(0, 1, 32'h42,       0, 1, 0, 0,  32'h100,      ST_TRAP, 32'h20, 1);
      vecs[12] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h100,      ST_RUN,  32'h20, 0);
      vecs[13] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h104,      ST_RUN,  32'h20, 0);
      // explicit trap; inputs during the TRAP cycle are ignored
      vecs[14] = mk(0, 1, 32'h30,       0, 1, 0, 0,  32'h30,       ST_RUN,  32'h20, 0);
      vecs[15] = mk(1, 0, 32'h0,        0, 1, 0, 0,  32'h100,      ST_TRAP, 32'h30, 0);
      vecs[16] = mk(1, 1, 32'h200,      0, 1, 0, 0,  32'h100,      ST_RUN,  32'h30, 0);
      // wrap-around at the top of the address space
      vecs[17] = mk(0, 1, 32'hFFFFFFFC, 0, 1, 0, 0,  32'hFFFFFFFC, ST_RUN,  32'h30, 0);
      vecs[18] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h0,        ST_RUN,  32'h30, 0);
      vecs[19] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h4,        ST_RUN,  32'h30, 0);
      vecs[20] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h8,        ST_RUN,  32'h30, 0);
      // halt beats redirect; five idle cycles with trap/redirect/halt ignored
      vecs[21] = mk(0, 1, 32'h80,       0, 1, 1, 0,  32'h8,        ST_HALT, 32'h30, 0);
      vecs[22] = mk(1, 0, 32'h0,        0, 1, 0, 0,  32'h8,        ST_HALT, 32'h30, 0);
      vecs[23] = mk(1, 1, 32'h42,       0, 1, 0, 0,  32'h8,        ST_HALT, 32'h30, 0);
      vecs[24] = mk(0, 1, 32'h80,       0, 1, 1, 0,  32'h8,        ST_HALT, 32'h30, 0);
      vecs[25] = mk(1, 0, 32'h0,        0, 1, 1, 0,  32'h8,        ST_HALT, 32'h30, 0);
      vecs[26] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h8,        ST_HALT, 32'h30, 0);
      vecs[27] = mk(0, 0, 32'h0,        0, 1, 0, 1,  32'h8,        ST_RUN,  32'h30, 0);
      vecs[28] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'hC,        ST_RUN,  32'h30, 0);
      // trap beats misaligned redirect (no misalign pulse), trap beats halt
      vecs[29] = mk(1, 1, 32'h42,       0, 1, 0, 0,  32'h100,      ST_TRAP, 32'hC,  0);
      vecs[30] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h100,      ST_RUN,  32'hC,  0);
      vecs[31] = mk(1, 0, 32'h0,        0, 1, 1, 0,  32'h100,      ST_TRAP, 32'h100,0);
      vecs[32] = mk(0, 0, 32'h0,        0, 1, 0, 0,  32'h100,      ST_RUN,  32'h100,0);
      // misaligned redirect beats halt and stall; then halt for the reset test
      vecs[33] = mk(0, 1, 32'h1,        1, 1, 1, 0,  32'h100,      ST_TRAP, 32'h100,1);
      vecs[34] = mk(0, 0, 32'h0,        0, 1, 1, 0,  32'h100,      ST_RUN,  32'h100,0);

      // ---------------- reset state ----------------
      idle_inputs();
      rst_ni = 1'b0;
      #12;
      chk("reset_pc",    pc,                 32'h0);
      chk("reset_state", {30'b0, state},     {30'b0, ST_BOOT});
      chk("reset_epc",   epc,                32'h0);
      chk("reset_mis",   {31'b0, misalign},  32'h0);
      chk("reset_valid", {31'b0, fetch_valid}, 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < NVEC; i++) begin
         trap        = vecs[i].trap;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         stall       = vecs[i].stall;
         imem_ready  = vecs[i].rdy;
         halt        = vecs[i].halt;
         resume      = vecs[i].resume;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pc", i),    pc,                     vecs[i].exp_pc);
         chk($sformatf("v%0d_pc4", i),   pc_plus4,               vecs[i].exp_pc + 32'd4);
         chk($sformatf("v%0d_state", i), {30'b0, state},         {30'b0, vecs[i].exp_state});
         chk($sformatf("v%0d_valid", i), {31'b0, fetch_valid},
             {31'b0, (vecs[i].exp_state == ST_RUN)});
         chk($sformatf("v%0d_epc", i),   epc,                    vecs[i].exp_epc);
         chk($sformatf("v%0d_mis", i),   {31'b0, misalign},      {31'b0, vecs[i].exp_mis});
         $display("[TB] vec %0d pc=0x%08h state=%0d epc=0x%08h mis=%0b",
                  i, pc, state, epc, misalign);
      end

      // ---------------- halt, then asynchronous reset mid-HALT ----------------
      idle_inputs();
      halt = 1;
      redirect = 1;
      redirect_pc = 32'h0000_0400;
      @(posedge clk);
      #1;
      chk("halt_state", {30'b0, state}, {30'b0, ST_HALT});
      chk("halt_pc",    pc,             32'h100);
      idle_inputs();
      trap = 1;
      @(negedge clk);
      #2;
      rst_ni = 1'b0;
      #1;
      // still before the next rising edge: reset must act without the clock
      chk("async_pc",    pc,                32'h0);
      chk("async_state", {30'b0, state},    {30'b0, ST_BOOT});
      chk("async_epc",   epc,               32'h0);
      chk("async_valid", {31'b0, fetch_valid}, 32'h0);
      $display("[TB] async reset pc=0x%08h state=%0d", pc, state);

      // release and confirm the boot delay restarts from zero
      idle_inputs();
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      chk("reboot1_state", {30'b0, state}, {30'b0, ST_BOOT});
      @(posedge clk);
      #1;
      chk("reboot2_state", {30'b0, state}, {30'b0, ST_RUN});
      chk("reboot2_pc",    pc,             32'h0);
      @(posedge clk);
      #1;
      chk("reboot3_pc",    pc,             32'h4);
      $display("[TB] reboot pc=0x%08h state=%0d", pc, state);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_pc_sequencer
